host_cmd_framer: RTL



---
 rtl/host_cmd_framer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/host_cmd_framer.sv
// host_cmd_framer: expands one host command into UART-framed bytes on Rx_line.
// Optional macro HOST_GAP_EN adds one idle-high bit period between bytes of a command.
module host_cmd_framer #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     Cmd_valid,
  output logic                     Cmd_ready,
  input  logic [1:0]               Cmd_type,
  input  logic [$clog2(depth)-1:0] Cmd_addr,
  input  logic [width-1:0]         Cmd_data,
  input  logic [width-1:0]         Cmd_A,
  input  logic [width-1:0]         Cmd_B,
  input  logic [3:0]               Cmd_FUN,
  input  logic [4:0]               Prescale,
  input  logic                     Parity_EN,
  input  logic                     Parity_type,
  output logic                     Rx_line,
  output logic                     Busy,
  output logic                     Cmd_done
);

`ifdef HOST_GAP_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`endif

  state_t          r_state, w_state_nxt;
  logic [4:0]      r_cnt, w_cnt_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [1:0]      r_byte, w_byte_nxt;
  logic [1:0]      r_nlast;
  logic [4:0]      r_p;
  logic            r_par_en, r_par_odd;
  logic [3:0][7:0] r_bytes;
  logic            r_line, w_line_nxt;
  logic            r_done, w_done_nxt;
  logic            w_accept, w_to_stop;
  logic            w_end, w_stop_early, w_last;
  logic [7:0]      w_cur;

  assign w_end        = (r_cnt == r_p - 5'd1);
  assign w_stop_early = (6'(r_cnt) + 6'd2 == 6'(r_p));
  assign w_last       = (r_byte == r_nlast);

  // The final stop bit's last cycle is spent in IDLE with Cmd_done high, so a
  // command accepted on that edge starts its frame with no idle cycle between.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_end ? 5'd0 : r_cnt + 5'd1;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    w_to_stop   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (Cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_START;
          w_bit_nxt   = '0;
          w_byte_nxt  = '0;
        end
      end
      S_START: if (w_end) w_state_nxt = S_DATA;
      S_DATA: if (w_end) begin
        if (r_bit == 3'd7) begin
          w_bit_nxt = '0;
          if (r_par_en) w_state_nxt = S_PARITY;
          else          w_to_stop   = 1'b1;
        end else begin
          w_bit_nxt = r_bit + 3'd1;
        end
      end
      S_PARITY: if (w_end) w_to_stop = 1'b1;
      S_STOP: begin
        if (w_last && w_stop_early) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_byte_nxt  = '0;
          w_done_nxt  = 1'b1;
        end else if (w_end) begin
`ifdef HOST_GAP_EN
          w_state_nxt = S_GAP;
`else
          w_state_nxt = S_START;
          w_byte_nxt  = r_byte + 2'd1;
`endif
        end
      end
`ifdef HOST_GAP_EN
      S_GAP: if (w_end) begin
        w_state_nxt = S_START;
        w_byte_nxt  = r_byte + 2'd1;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    // With P=1 the last stop bit is only the IDLE cycle, so STOP is skipped.
    if (w_to_stop) begin
      if (w_last && r_p == 5'd1) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_byte_nxt  = '0;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = S_STOP;
      end
    end

    w_cur      = r_bytes[w_byte_nxt];
    w_line_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_line_nxt = 1'b0;
      S_DATA:   w_line_nxt = w_cur[w_bit_nxt];
      S_PARITY: w_line_nxt = r_par_odd ^ (^w_cur);
      default:  w_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_nlast   <= '0;
      r_p       <= 5'd1;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_bytes   <= '0;
      r_line    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_line  <= w_line_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_p       <= (Prescale == 5'd0) ? 5'd1 : Prescale;
        r_par_en  <= Parity_EN;
        r_par_odd <= Parity_type;
        unique case (Cmd_type)
          2'd0: begin
            r_bytes <= {8'h00, 8'(Cmd_data), 8'(Cmd_addr), 8'hAA};
            r_nlast <= 2'd2;
          end
          2'd1: begin
            r_bytes <= {16'h0000, 8'(Cmd_addr), 8'hBB};
            r_nlast <= 2'd1;
          end
          2'd2: begin
            r_bytes <= {8'(Cmd_FUN), 8'(Cmd_B), 8'(Cmd_A), 8'hCC};
            r_nlast <= 2'd3;
          end
          default: begin
            r_bytes <= {16'h0000, 8'(Cmd_FUN), 8'hDD};
            r_nlast <= 2'd1;
          end
        endcase
      end
    end
  end

  assign Cmd_ready = (r_state == S_IDLE);
  assign Busy      = !Cmd_ready;
  assign Rx_line   = r_line;
  assign Cmd_done  = r_done;

endmodule
